fetch_stage: RTL
================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, prefetch buffer entries; power of two, >= 2.
REQ-002 Parameter XLEN, default 32, address and instruction width.
REQ-003 clk_i  in  1  single clock; all state updates on its rising edge.
REQ-004 rst_ni  in  1  asynchronous, active-low reset.
REQ-005 boot_addr_i  in  XLEN  first fetch address after reset.
REQ-006 fetch_en_i  in  1  permits issue of new fetch requests.
REQ-007 instr_req_o  out  1  fetch request to instruction memory.
REQ-008 instr_addr_o  out  XLEN  fetch address, word aligned.
REQ-009 instr_gnt_i  in  1  request accepted this cycle.
REQ-010 instr_rvalid_i  in  1  response data valid, in request order.
REQ-011 instr_rdata_i  in  XLEN  response instruction word.
REQ-012 redirect_i  in  1  branch/jump taken; flush and refetch.
REQ-013 redirect_addr_i  in  XLEN  new fetch target.
REQ-014 id_ready_i  in  1  ID stage accepts the presented instruction.
REQ-015 instr_valid_id_o  out  1  presented instruction valid.
REQ-016 instr_rdata_id_o  out  XLEN  presented instruction.
REQ-017 pc_id_o  out  XLEN  address of presented instruction.

Function
REQ-018 FSM states: IDLE (no issue; fetch_addr_q loads boot_addr_i each cycle), RUN (issue enabled); IDLE->RUN when fetch_en_i=1; RUN->IDLE never except reset.
REQ-019 In RUN, instr_req_o=1 iff fetch_en_i=1, redirect_i=0, and outstanding + fifo_count < FIFO_DEPTH.
REQ-020 instr_addr_o = fetch_addr_q; on instr_req_o & instr_gnt_i, fetch_addr_q += 4 (modulo 2^XLEN) and outstanding increments.
REQ-021 Memory contract: at most one grant per cycle, responses in order, earliest rvalid one cycle after grant; request may be withdrawn before grant.
REQ-022 On instr_rvalid_i, outstanding decrements; if discard_q=0 the entry {pc, rdata} is pushed, pc = address of the matching request, else discard_q decrements and data is dropped.
REQ-023 FIFO head drives instr_valid_id_o/instr_rdata_id_o/pc_id_o combinationally from registered storage; latency rvalid -> valid is exactly one cycle.
REQ-024 Pop when instr_valid_id_o & id_ready_i; push and pop in the same cycle keep fifo_count unchanged; full FIFO never receives a push (guaranteed by REQ-019).
REQ-025 redirect_i (any state): FIFO cleared next cycle; fetch_addr_q <= redirect_addr_i with bits [1:0] forced to 0; discard_q <= outstanding after this cycle's grant/rvalid updates; instr_req_o=0 this cycle.
REQ-026 redirect_i with simultaneous rvalid: that response dropped; with simultaneous pop: pop ignored; redirect overrides all.
REQ-027 redirect_i in IDLE: fetch_addr_q takes redirect_addr_i instead of boot_addr_i.
REQ-028 fetch_en_i low in RUN: no new requests; outstanding responses still complete into FIFO.
REQ-029 Counters outstanding and discard_q are $clog2(FIFO_DEPTH)+1 bits; never overflow or underflow.

Reset
REQ-030 On rst_ni=0: state IDLE, fetch_addr_q=0, outstanding=0, discard_q=0, FIFO empty.
REQ-031 Outputs under reset: instr_req_o=0, instr_valid_id_o=0, instr_addr_o=0, instr_rdata_id_o=0, pc_id_o=0.
REQ-032 Reset mid-transaction abandons outstanding requests; responses arriving after reset release are not expected.

Structure
REQ-033 riscv_cpu_pkg holds fetch FSM state enum and fetch entry struct {pc, instr}.
REQ-034 One sub-module fetch_fifo (parametrised depth/width, push/pop/flush, count, full/empty).

Verification
REQ-035 Boot 0x1000, fetch_en_i=1, gnt always, rvalid 1 cycle later, id_ready_i=1 -> ID sees PCs 0x1000, 0x1004, 0x1008 on consecutive cycles.
REQ-036 id_ready_i=0 held, FIFO_DEPTH=4 -> exactly 4 grants, instr_req_o then 0 until a pop.
REQ-037 Redirect to 0x2002 with 2 outstanding -> next two rvalids dropped, first valid PC 0x2000.
REQ-038 redirect_i coincident with rvalid and pop -> FIFO empty next cycle, no stale PC ever presented.
REQ-039 fetch_addr 0xFFFFFFFC granted -> next instr_addr_o 0x00000000.
REQ-040 rst_ni asserted mid-burst -> all outputs 0 asynchronously; after release, fetch restarts at boot_addr_i.

Source files
------------

// File: rtl/riscv_cpu_pkg.sv
// Shared fetch-stage types: FSM state encoding and the prefetch buffer entry layout.
package riscv_cpu_pkg;

  localparam int unsigned XlenDefault = 32;

  typedef logic [0:0] fetch_state_t;

  localparam fetch_state_t FetchIdle = 1'b0;
  localparam fetch_state_t FetchRun  = 1'b1;

  typedef struct packed {
    logic [XlenDefault-1:0] pc;
    logic [XlenDefault-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch buffer: circular FIFO with push/pop/flush; head is read combinationally from storage.
module fetch_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 64
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   push_i,
  input  logic [Width-1:0]       wdata_i,
  input  logic                   pop_i,
  input  logic                   flush_i,
  output logic [Width-1:0]       rdata_o,
  output logic [$clog2(Depth):0] count_o,
  output logic                   full_o,
  output logic                   empty_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wptr_q, wptr_d;
  logic [PtrW-1:0]  rptr_q, rptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             push_en, pop_en;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CntW'(Depth));
  assign count_o = count_q;
  assign push_en = push_i & ~flush_i & ~full_o;
  assign pop_en  = pop_i & ~flush_i & ~empty_o;

  // Empty head reads as zero so stale storage never leaks onto the outputs.
  assign rdata_o = empty_o ? '0 : mem_q[rptr_q];

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (flush_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (push_en) wptr_d = wptr_q + PtrW'(1);
      if (pop_en)  rptr_d = rptr_q + PtrW'(1);
      count_d = count_q + CntW'(push_en) - CntW'(pop_en);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_en) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: issues in-order word fetches, buffers responses in a prefetch FIFO
// and presents them to ID; redirects flush the buffer and drop in-flight responses.
module fetch_stage
  import riscv_cpu_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned XLEN       = 32
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic [XLEN-1:0] boot_addr_i,
  input  logic            fetch_en_i,
  output logic            instr_req_o,
  output logic [XLEN-1:0] instr_addr_o,
  input  logic            instr_gnt_i,
  input  logic            instr_rvalid_i,
  input  logic [XLEN-1:0] instr_rdata_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_addr_i,
  input  logic            id_ready_i,
  output logic            instr_valid_id_o,
  output logic [XLEN-1:0] instr_rdata_id_o,
  output logic [XLEN-1:0] pc_id_o
);

  localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] fetch_addr_q, fetch_addr_d;
  logic [CntW-1:0] outstanding_q, outstanding_d;
  logic [CntW-1:0] discard_q, discard_d;

  logic [CntW-1:0]   fifo_count;
  logic              fifo_full, fifo_empty;
  logic              fifo_push, fifo_pop;
  logic [2*XLEN-1:0] fifo_wdata, fifo_rdata;
  logic              unused_fifo_full;

  logic [CntW:0]     occupancy;
  logic [CntW-1:0]   live_cnt;
  logic [XLEN-1:0]   rsp_pc;
  logic              gnt_fire;

  assign unused_fifo_full = fifo_full;

  // Buffer slots already promised: in-flight responses plus entries waiting for ID.
  assign occupancy = (CntW+1)'(outstanding_q) + (CntW+1)'(fifo_count);

  assign instr_req_o  = (state_q == FetchRun) & fetch_en_i & ~redirect_i &
                        (occupancy < (CntW+1)'(FIFO_DEPTH));
  assign instr_addr_o = fetch_addr_q;
  assign gnt_fire     = instr_req_o & instr_gnt_i;

  // Non-discarded in-flight requests are contiguous and end just below fetch_addr_q,
  // so the oldest one's address is recovered without storing per-request addresses.
  assign live_cnt = outstanding_q - discard_q;
  assign rsp_pc   = fetch_addr_q - (XLEN'(live_cnt) << 2);

  assign fifo_push  = instr_rvalid_i & (discard_q == '0) & ~redirect_i;
  assign fifo_pop   = instr_valid_id_o & id_ready_i & ~redirect_i;
  assign fifo_wdata = {rsp_pc, instr_rdata_i};

  assign instr_valid_id_o = ~fifo_empty;
  assign pc_id_o          = fifo_rdata[2*XLEN-1:XLEN];
  assign instr_rdata_id_o = fifo_rdata[XLEN-1:0];

  always_comb begin
    state_d = state_q;
    if ((state_q == FetchIdle) && fetch_en_i) state_d = FetchRun;
  end

  always_comb begin
    fetch_addr_d = fetch_addr_q;
    if (redirect_i) begin
      fetch_addr_d = {redirect_addr_i[XLEN-1:2], 2'b00};
    end else if (state_q == FetchIdle) begin
      fetch_addr_d = {boot_addr_i[XLEN-1:2], 2'b00};
    end else if (gnt_fire) begin
      fetch_addr_d = fetch_addr_q + XLEN'(4);
    end
  end

  always_comb begin
    outstanding_d = outstanding_q + CntW'(gnt_fire) - CntW'(instr_rvalid_i);
    discard_d     = discard_q;
    if (redirect_i) begin
      discard_d = outstanding_d;
    end else if (instr_rvalid_i && (discard_q != '0)) begin
      discard_d = discard_q - CntW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= FetchIdle;
      fetch_addr_q  <= '0;
      outstanding_q <= '0;
      discard_q     <= '0;
    end else begin
      state_q       <= state_d;
      fetch_addr_q  <= fetch_addr_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
    end
  end

  fetch_fifo #(
    .Depth (FIFO_DEPTH),
    .Width (2 * XLEN)
  ) u_fetch_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (fifo_push),
    .wdata_i (fifo_wdata),
    .pop_i   (fifo_pop),
    .flush_i (redirect_i),
    .rdata_o (fifo_rdata),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

endmodule
